// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a ROM table of I2C register writes through the I2C block CSRs after a start pulse.
// Optional per-poll timeout enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_init_sequencer #(
  parameter int pBusAdrsBit = 16,
  parameter logic [pBusAdrsBit-1:0] pI2CBase = 'h0400,
  parameter int pDivValue = 250,
  parameter int pTableAdrsBit = 5,
  parameter int pTimeout = 65535
) (
  input  logic                     iSysClk,
  input  logic                     iSysRst,
  input  logic                     iStart,
  output logic [pTableAdrsBit-1:0] oTableAdrs,
  input  logic [23:0]              iTableData,
  output logic [31:0]              oMUsiWd,
  output logic [pBusAdrsBit-1:0]   oMUsiAdrs,
  output logic                     oMUsiWCke,
  input  logic [31:0]              iMUsiRd,
  input  logic                     iMUsiREd,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oErr,
  output logic [pTableAdrsBit-1:0] oEntryCnt
);
  typedef enum logic [3:0] {
    IDLE, WDIV, FETCH, DECODE, WTX, WEN1, POLL_BUSY, WEN0, POLL_IDLE, NEXT, DONE, ERR
  } state_t;
  localparam logic [pBusAdrsBit-1:0] EN_A  = pI2CBase;
  localparam logic [pBusAdrsBit-1:0] DIV_A = pI2CBase + pBusAdrsBit'(4);
  localparam logic [pBusAdrsBit-1:0] TX_A  = pI2CBase + pBusAdrsBit'(8);
  localparam logic [pBusAdrsBit-1:0] ST_A  = pI2CBase + pBusAdrsBit'('h84);
  state_t state_q, state_d;
  logic [23:0] word_q, word_d;
  logic [pTableAdrsBit-1:0] tadr_q, tadr_d, cnt_q, cnt_d;
  logic [31:0] wd_q, wd_d;
  logic [pBusAdrsBit-1:0] adrs_q, adrs_d;
  logic wcke_q, wcke_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic ok_busy, ok_idle, tmo;
`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] tmr_q, tmr_d;
  always_comb begin
    tmr_d = (state_q == POLL_BUSY || state_q == POLL_IDLE) ? tmr_q + 16'd1 : '0;
    tmo = tmr_q == 16'(pTimeout - 1);
  end
  always_ff @(posedge iSysClk) begin
    if (iSysRst) tmr_q <= '0;
    else tmr_q <= tmr_d;
  end
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    tadr_d = tadr_q;
    cnt_d = cnt_q;
    done_d = done_q;
    err_d = err_q;
    ok_busy = iMUsiREd && iMUsiRd != 32'd0;
    ok_idle = iMUsiREd && iMUsiRd != 32'd1;
    unique case (state_q)
      IDLE: if (iStart) begin
        state_d = WDIV;
        done_d = 1'b0;
        err_d = 1'b0;
        cnt_d = '0;
        tadr_d = '0;
      end
      WDIV:      state_d = FETCH;
      FETCH:     state_d = DECODE;
      DECODE: begin
        word_d = iTableData;
        state_d = (iTableData == 24'hFFFFFF) ? DONE : WTX;
      end
      WTX:       state_d = WEN1;
      WEN1:      state_d = POLL_BUSY;
      POLL_BUSY: state_d = ok_busy ? WEN0 : tmo ? ERR : POLL_BUSY;
      WEN0:      state_d = POLL_IDLE;
      POLL_IDLE: state_d = ok_idle ? NEXT : tmo ? ERR : POLL_IDLE;
      // the last table slot ends the walk instead of wrapping back to entry 0
      NEXT: begin
        cnt_d = cnt_q + 1'b1;
        tadr_d = (&tadr_q) ? tadr_q : tadr_q + 1'b1;
        state_d = (&tadr_q) ? DONE : FETCH;
      end
      default:   state_d = IDLE;
    endcase
    if (state_d == DONE) done_d = 1'b1;
    if (state_d == ERR) err_d = 1'b1;
    // bus outputs are registered from the next state so each write lands in its own state cycle
    wcke_d = state_d inside {WDIV, WTX, WEN1, WEN0, ERR};
    adrs_d = state_d == WDIV ? DIV_A :
             state_d == WTX ? TX_A :
             state_d inside {POLL_BUSY, POLL_IDLE} ? ST_A :
             state_d inside {WEN1, WEN0, ERR} ? EN_A : '0;
    wd_d = state_d == WDIV ? 32'(pDivValue) :
           state_d == WTX ? {8'h0, word_d} :
           state_d == WEN1 ? 32'd1 : '0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      state_q <= IDLE;
      word_q <= '0;
      tadr_q <= '0;
      cnt_q <= '0;
      wd_q <= '0;
      adrs_q <= '0;
      wcke_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      tadr_q <= tadr_d;
      cnt_q <= cnt_d;
      wd_q <= wd_d;
      adrs_q <= adrs_d;
      wcke_q <= wcke_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign oTableAdrs = tadr_q;
  assign oMUsiWd = wd_q;
  assign oMUsiAdrs = adrs_q;
  assign oMUsiWCke = wcke_q;
  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oErr = err_q;
  assign oEntryCnt = cnt_q;
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: random table walks scored against a table-level model of expected CSR writes.
module tb_i2c_init_sequencer;
  localparam logic [15:0] EN_A = 16'h0400, DIV_A = 16'h0404, TX_A = 16'h0408, ST_A = 16'h0484;
  logic clk = 0, rst = 1, start = 0, red = 0;
  logic [4:0] tadr, cnt;
  logic [23:0] tdata = 0;
  logic [31:0] wd, rd = 0;
  logic [15:0] adrs;
  logic wcke, busy, done, err;
  always #5 clk = ~clk;

  i2c_init_sequencer #(.pTimeout(100)) dut (
    .iSysClk(clk), .iSysRst(rst), .iStart(start), .oTableAdrs(tadr), .iTableData(tdata),
    .oMUsiWd(wd), .oMUsiAdrs(adrs), .oMUsiWCke(wcke), .iMUsiRd(rd), .iMUsiREd(red),
    .oBusy(busy), .oDone(done), .oErr(err), .oEntryCnt(cnt)
  );

  int checks = 0, errors = 0;
  logic [23:0] rom [32];
  logic [47:0] exp_q [$];
  int exp_cnt, exp_tadr;
  logic stuck0 = 0, hold1 = 0, stat = 0, tgt = 0;
  int cd = 0;
  logic [4:0] ap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected CSR write list derived from the table contents
  function automatic void model();
    int n = 0;
    exp_q.push_back({DIV_A, 32'd250});
    while (n < 32 && rom[n] != 24'hFFFFFF) begin
      exp_q.push_back({TX_A, 8'h0, rom[n]});
      exp_q.push_back({EN_A, 32'd1});
      exp_q.push_back({EN_A, 32'd0});
      n++;
    end
    exp_cnt = n % 32;
    exp_tadr = (n == 32) ? 31 : n;
  endfunction

  function automatic logic [23:0] rand_word();
    logic [23:0] w = 24'($urandom);
    return (w == 24'hFFFFFF) ? 24'h0 : w;
  endfunction

  task automatic fill(input int n, input bit term);
    for (int a = 0; a < 32; a++) rom[a] = rand_word();
    if (term) rom[n] = 24'hFFFFFF;
  endtask

  // ROM with one-cycle latency plus an I2C status responder
  initial forever begin
    @(negedge clk);
    tdata = rom[ap];
    ap = tadr;
    if (wcke && adrs == EN_A) begin
      tgt = wd[0];
      cd = $urandom_range(0, 4);
    end else if (cd > 0) cd--;
    else stat = tgt;
    if (stuck0) stat = 0;
    if (hold1) stat = 1;
    red = ($urandom_range(0, 2) != 0);
    rd = red ? {31'b0, stat} : $urandom;
  end

  initial forever begin
    @(negedge clk);
    if (wcke) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h@%0h expected none", wd, adrs);
      end else chk("csr_write", {adrs, wd}, exp_q.pop_front());
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_to_div_wcke", {wcke, adrs}, {1'b1, DIV_A});
    chk("busy_after_start", busy, 1);
  endtask

  task automatic go(input bit poke);
    int i = 0;
    bit poked = 0;
    model();
    pulse_start();
    while (!done && i < 5000) begin
      @(negedge clk);
      i++;
      if (poke && !poked && adrs == ST_A) begin
        start = 1;
        poked = 1;
      end else start = 0;
    end
    start = 0;
    chk("done_reached", done, 1);
    chk("busy_during_done", busy, 1);
    @(negedge clk);
    chk("busy_dropped", busy, 0);
    chk("entry_cnt", cnt, exp_cnt);
    chk("table_adrs", tadr, exp_tadr);
    chk("err_clear", err, 0);
    chk("writes_left", exp_q.size(), 0);
  endtask

  initial begin
    int i;
    for (int a = 0; a < 32; a++) rom[a] = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {wd, adrs, wcke, tadr, busy, done, err, cnt}, 0);
    rst = 0;
    rom[0] = 24'h1A0512;
    rom[1] = 24'hFFFFFF;
    go(0);
    fill(3, 1);
    go(0);
    fill(5, 1);
    go(1);
    fill(0, 1);
    go(0);
    // reset while waiting for the I2C block to go idle
    fill(3, 1);
    model();
    hold1 = 1;
    pulse_start();
    i = 0;
    while (!(wcke && adrs == EN_A && wd == 0) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("reached_en0", i < 2000, 1);
    repeat (3) @(negedge clk);
    chk("in_poll_idle", adrs, ST_A);
    rst = 1;
    @(negedge clk);
    chk("midrun_reset_outputs", {wd, adrs, wcke, tadr, busy, done, err, cnt}, 0);
    rst = 0;
    hold1 = 0;
    exp_q.delete();
    fill(3, 1);
    go(0);
    fill(0, 0);
    go(0);
    for (int k = 0; k < 4; k++) begin
      fill($urandom_range(1, 6), 1);
      go(k[0]);
    end
    // status never reports the transfer accepted
    stuck0 = 1;
    fill(1, 1);
    model();
    pulse_start();
`ifdef I2C_SEQ_TIMEOUT_EN
    i = 0;
    begin
      int pc = 0;
      while (!err && i < 2000) begin
        @(negedge clk);
        i++;
        if (adrs == ST_A) pc++;
      end
      chk("poll_cycles", pc, 100);
    end
    chk("err_set", err, 1);
    chk("done_clear", done, 0);
    @(negedge clk);
    chk("busy_after_err", busy, 0);
    chk("writes_left_err", exp_q.size(), 0);
`else
    repeat (300) @(negedge clk);
    chk("stuck_busy", busy, 1);
    chk("stuck_err", err, 0);
    chk("stuck_done", done, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_q.delete();
`endif
    stuck0 = 0;
    tgt = 0;
    cd = 0;
    stat = 0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_init_sequencer.md
# i2c_init_sequencer

Autonomous USI-bus master sitting directly upstream of the I2C block. On a start pulse it walks a table of I2C register writes held in an external ROM and, for each entry, programs the I2C block's CSRs (divider, TX word, enable) and polls its status register through the enable/busy/idle handshake. Used to bring up I2C peripherals (codec, PMIC) after reset without CPU involvement.

## Interface
- pBusAdrsBit, 16, USI address width
- pI2CBase, 'h0400, I2C block CSR base; EN = base+'h00, DIV = base+'h04, TX = base+'h08, STATUS = base+'h84
- pDivValue, 250, value written to DIV before the first entry
- pTableAdrsBit, 5, table address width (max 32 entries)
- pTimeout, 65535, poll-cycle limit per wait state (only with macro)

- iSysClk  in  1  system clock; all logic on rising edge
- iSysRst  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle start pulse; ignored unless idle
- oTableAdrs  out  pTableAdrsBit  ROM read address
- iTableData  in  24  ROM word {slave[7:0], reg[7:0], data[7:0]}, valid one cycle after oTableAdrs changes
- oMUsiWd  out  32  CSR write data
- oMUsiAdrs  out  pBusAdrsBit  CSR address
- oMUsiWCke  out  1  one-cycle write strobe
- iMUsiRd  in  32  CSR read data
- iMUsiREd  in  1  read data valid
- oBusy  out  1  sequence in progress
- oDone  out  1  sticky, set when terminator reached
- oErr  out  1  sticky, set on timeout
- oEntryCnt  out  pTableAdrsBit  entries completed

## Operation
- States: IDLE, WDIV, FETCH, DECODE, WTX, WEN1, POLL_BUSY, WEN0, POLL_IDLE, NEXT, DONE, ERR.
- IDLE: iStart -> clear oDone/oErr/oEntryCnt, oTableAdrs=0, go WDIV.
- WDIV: write pDivValue to DIV -> FETCH.
- FETCH: hold address one cycle -> DECODE samples iTableData.
- DECODE: 24'hFFFFFF = terminator -> DONE; otherwise latch word -> WTX.
- WTX: write {8'h0, word} to TX -> WEN1 writes 1 to EN -> POLL_BUSY.
- POLL_BUSY: oMUsiAdrs=STATUS; on iMUsiREd with iMUsiRd != 0 -> WEN0 (transfer accepted).
- WEN0: write 0 to EN -> POLL_IDLE; on iMUsiREd with iMUsiRd != 1 -> NEXT.
- NEXT: oEntryCnt+1, oTableAdrs+1; if oTableAdrs was all-ones -> DONE (wrap forbidden), else FETCH.
- DONE: set oDone, -> IDLE. ERR: set oErr, write 0 to EN, -> IDLE.
- iStart while busy is ignored; not queued.
- Read data sampled only when iMUsiREd=1; iMUsiRd otherwise don't-care.

## Timing
- Reset: all outputs 0 (oMUsiAdrs 0, oMUsiWd 0, oMUsiWCke 0, oTableAdrs 0), state IDLE; reset mid-sequence aborts immediately, no EN=0 cleanup write.
- Each write state lasts exactly one cycle: oMUsiWd/oMUsiAdrs registered together with oMUsiWCke=1; next cycle oMUsiWCke=0.
- iStart to first WCke (DIV): 1 cycle. DECODE to TX write: 1 cycle.
- Entry overhead excluding poll time: 6 cycles (FETCH, DECODE, WTX, WEN1, WEN0, NEXT).
- oBusy is high from the cycle after iStart until the cycle DONE/ERR returns to IDLE.

## Configuration
- I2C_SEQ_TIMEOUT_EN defined: 16-bit counter cleared on entry to each POLL state, increments per cycle; reaching pTimeout -> ERR.
- Undefined: no counter, POLL states wait indefinitely; oErr tied 0.

## Test plan
- Reset then iStart with table {24'h1A0512, 24'hFFFFFF}: writes DIV=250 @'h0404, TX='h1A0512 @'h0408, EN=1 @'h0400; status model 0->1->0; EN=0; oDone=1, oEntryCnt=1.
- Three entries then terminator: exactly 3 TX writes in order, oEntryCnt=3, oBusy drops 1 cycle after DONE.
- iStart pulsed during POLL_BUSY: ignored, no extra DIV write, sequence unchanged.
- Status stuck at 0 with macro, pTimeout=100: ERR after 100 poll cycles, EN=0 written, oErr=1, oDone=0; without macro: oBusy stays 1.
- iSysRst asserted during POLL_IDLE: next cycle all outputs 0, state IDLE; fresh iStart restarts from entry 0.
- 32 valid entries, no terminator: stops at address 31, oDone=1, oEntryCnt wraps to 0, no address-0 refetch.
